mul8_seq_ctrl: RTL and testbench
================================

# mul8_seq_ctrl

Sequencing controller that computes an 8x8 → 16-bit product with one shared 4x4 combinational array multiplier. Each operand is split into nibbles, and the four partial products are fed through the multiplier over successive cycles. Each partial product is shifted and accumulated. The controller sits between the pin-level wrapper and the 4x4 array datapath, with a valid/ready handshake on both sides.

## Interface
- LAT_REG, 0, 1 = register the 4x4 product before accumulation (adds one cycle of latency, shortens the critical path)
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller accepts operands (IDLE only)
- a  in  8  multiplicand
- b  in  8  multiplier
- out_valid  out  1  product valid; held until accepted
- out_ready  in  1  consumer accepts product
- product  out  16  result
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, MUL, DRAIN (only when LAT_REG=1), DONE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: latch a, b; clear acc; step=0; go to MUL.
- MUL: drive the 4x4 unit per step:
  - step 0: aL·bL <<0
  - step 1: aH·bL <<4
  - step 2: aL·bH <<4
  - step 3: aH·bH <<8
- Accumulation:
  - LAT_REG=0: acc += shifted product each MUL cycle.
  - LAT_REG=1: product registered first; accumulate lags one cycle; DRAIN absorbs the final term.
- After the last accumulate: product <= acc (sign-corrected when configured); out_valid=1; go to DONE.
- DONE: product and out_valid stay stable while out_ready=0. On out_ready, go to IDLE and clear out_valid.
- Width rules:
  - acc is 16-bit unsigned; never overflows (max 255·255 = 0xFE01).
  - Partial products are 8-bit, zero-extended before shifting.
- in_valid outside IDLE is ignored. Operands are not sampled and no queueing occurs.
- in_ready is low in DONE, including the cycle out_ready is seen. A new operand is accepted no earlier than the cycle after return to IDLE.
- busy=1 in MUL, DRAIN and DONE.

## Timing
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; step=0; acc=0; product=0x0000; out_valid=0.
  - in_ready=0 while rst_n is low; in_ready=1 in the first cycle after release.
  - busy=0.
- Reset mid-operation aborts immediately. The partial result is discarded and no out_valid is produced.
- Latency, from accept edge to the edge at which out_valid rises:
  - 4 cycles (LAT_REG=0)
  - 5 cycles (LAT_REG=1)
- Throughput: one result per latency+2 cycles when out_ready is held high.
- All outputs are registered except in_ready and busy, which decode directly from the state register.

## Configuration
- MUL8_SEQ_SIGNED_EN defined:
  - a and b are two's complement.
  - At accept, latch |a|, |b| (as 8-bit unsigned; |-128| = 128) and sign = a[7]^b[7].
  - Final product = sign ? -acc : acc (16-bit two's complement).
  - Latency is unchanged.
- Undefined: a and b are unsigned. The sign logic is absent, and product = acc.

## Structure
- Package mul8_seq_pkg:
  - state enum (IDLE, MUL, DRAIN, DONE)
  - NIB_W=4, OP_W=8, RES_W=16
  - NUM_STEPS=4
  - the step→shift constant table (0, 4, 4, 8)
- Sub-module mul4x4_array: combinational 4x4 unsigned array multiplier (AND partial products, ripple full-adder array, 8-bit result). Instantiated once.
- The controller holds the FSM, step counter, operand/acc registers, optional pipeline register, and sign logic.

## Test plan
- a=0xFF, b=0xFF, out_ready=1 → out_valid rises 4 cycles after accept (5 with LAT_REG=1); product=0xFE01; busy falls the cycle after out handshake.
- a=0x12, b=0x34 → product=0x03A8. Also a=0x00, b=0xC7 → product=0x0000.
- Backpressure: a=0x0F, b=0x10, out_ready=0 for 3 cycles after out_valid → product holds 0x00F0 and in_ready stays 0. A second in_valid (a=0x01, b=0x01) pulsed during DONE is ignored. After out_ready, the next accepted op yields 0x0001.
- Reset mid-op: rst_n=0 during step 2 → next edge: out_valid=0, product=0x0000, busy=0. A following op a=0x0A, b=0x0B yields 0x006E.
- Signed build:
  - 0x80·0x80 → 0x4000
  - 0x80·0x7F → 0xC080
  - 0xFF·0x02 → 0xFFFE
  - Unsigned build: 0x80·0x7F → 0x3F80.
- Randomized back-to-back traffic, both LAT_REG values: every accepted pair matches a reference multiply, with no lost or duplicated results.

Source files
------------

// File: rtl/mul8_seq_ctrl_pkg.sv
// Package mul8_seq_pkg: shared widths, FSM state type and the per-step
// partial-product shift table for the 8x8 sequential multiplier.
// Exports: NIB_W, OP_W, RES_W, NUM_STEPS, STEP_W, state_t, SHIFT_TBL, shift_pp().
package mul8_seq_pkg;

  localparam int unsigned NIB_W     = 4;
  localparam int unsigned OP_W      = 8;
  localparam int unsigned RES_W     = 16;
  localparam int unsigned NUM_STEPS = 4;
  localparam int unsigned STEP_W    = $clog2(NUM_STEPS);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DRAIN,
    DONE
  } state_t;

  // step 0: aL*bL, step 1: aH*bL, step 2: aL*bH, step 3: aH*bH
  localparam int unsigned SHIFT_TBL [NUM_STEPS] = '{0, 4, 4, 8};

  // Zero-extend an 8-bit partial product to result width and align it.
  function automatic logic [RES_W-1:0] shift_pp(input logic [2*NIB_W-1:0] pp,
                                                input logic [STEP_W-1:0]  step);
    logic [RES_W-1:0] ext;
    ext = {{(RES_W-2*NIB_W){1'b0}}, pp};
    return ext << SHIFT_TBL[step];
  endfunction

endpackage

// File: rtl/mul8_seq_ctrl_if.sv
// Interface mul8_seq_ctrl_if: operand and result valid/ready handshakes.
//   in_valid/in_ready/a/b        : operand channel (master -> controller)
//   out_valid/out_ready/product  : result channel (controller -> master)
// Modports: master (operand source / result sink), slave (controller).
interface mul8_seq_ctrl_if;
  import mul8_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  a;
  logic [OP_W-1:0]  b;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/mul8_seq_ctrl_mul4x4_array.sv
// mul4x4_array: combinational 4x4 unsigned array multiplier.
// AND-gate partial products summed row by row through ripple full adders.
//   i_a, i_b : 4-bit unsigned operands
//   o_p      : 8-bit unsigned product
module mul4x4_array
  import mul8_seq_pkg::*;
(
  input  logic [NIB_W-1:0]   i_a,
  input  logic [NIB_W-1:0]   i_b,
  output logic [2*NIB_W-1:0] o_p
);

  localparam int unsigned AI_W = $clog2(NIB_W);
  localparam int unsigned SI_W = $clog2(2*NIB_W);

  always_comb begin
    logic [2*NIB_W-1:0] w_sum;
    logic               w_c;
    logic               w_pp;
    logic               w_s;

    w_sum = '0;
    w_c   = 1'b0;
    w_pp  = 1'b0;
    w_s   = 1'b0;
    for (int unsigned j = 0; j < NIB_W; j++) begin
      w_sum[SI_W'(j)] = i_a[AI_W'(j)] & i_b[0];
    end
    // Each further row of partial products is rippled into the running sum.
    for (int unsigned i = 1; i < NIB_W; i++) begin
      w_c = 1'b0;
      for (int unsigned j = 0; j < 2*NIB_W; j++) begin
        w_pp = 1'b0;
        if (j >= i && j < i + NIB_W) begin
          w_pp = i_a[AI_W'(j - i)] & i_b[AI_W'(i)];
        end
        w_s = w_sum[SI_W'(j)] ^ w_pp ^ w_c;
        w_c = (w_sum[SI_W'(j)] & w_pp) | (w_c & (w_sum[SI_W'(j)] ^ w_pp));
        w_sum[SI_W'(j)] = w_s;
      end
    end
    o_p = w_sum;
  end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: 8x8 -> 16-bit multiplier sequenced over one shared 4x4
// array multiplier, four nibble partial products shifted and accumulated.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mul8_seq_ctrl_if.slave (operand and result handshakes)
//   busy       : high whenever the FSM is not IDLE
// Parameter LAT_REG (0/1): register each partial product before accumulating.
// Macro MUL8_SEQ_SIGNED_EN: treat a/b as two's complement (sign-magnitude core).
module mul8_seq_ctrl
  import mul8_seq_pkg::*;
#(
  parameter int unsigned LAT_REG = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  mul8_seq_ctrl_if.slave  bus,
  output logic            busy
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  state_t             r_state;
  logic [STEP_W-1:0]  r_step;
  logic [OP_W-1:0]    r_a;
  logic [OP_W-1:0]    r_b;
  logic [RES_W-1:0]   r_acc;
  logic [RES_W-1:0]   r_pp_q;
  logic [RES_W-1:0]   r_product;
  logic               r_out_valid;

  logic [NIB_W-1:0]   w_nib_a;
  logic [NIB_W-1:0]   w_nib_b;
  logic [2*NIB_W-1:0] w_pp;
  logic [RES_W-1:0]   w_term;
  logic [RES_W-1:0]   w_last_sum;
  logic [RES_W-1:0]   w_result;
  logic [OP_W-1:0]    w_a_lat;
  logic [OP_W-1:0]    w_b_lat;

  // step bit 0 selects the high nibble of a, bit 1 the high nibble of b
  assign w_nib_a = r_step[0] ? r_a[OP_W-1:NIB_W] : r_a[NIB_W-1:0];
  assign w_nib_b = r_step[1] ? r_b[OP_W-1:NIB_W] : r_b[NIB_W-1:0];

  mul4x4_array u_mul (
    .i_a (w_nib_a),
    .i_b (w_nib_b),
    .o_p (w_pp)
  );

  assign w_term = shift_pp(w_pp, r_step);

  // The final term is added on the way into r_product, not into r_acc.
  assign w_last_sum = r_acc + ((LAT_REG != 0) ? r_pp_q : w_term);

`ifdef MUL8_SEQ_SIGNED_EN
  logic r_sign;
  assign w_a_lat  = bus.a[OP_W-1] ? (~bus.a + 1'b1) : bus.a;
  assign w_b_lat  = bus.b[OP_W-1] ? (~bus.b + 1'b1) : bus.b;
  assign w_result = r_sign ? (~w_last_sum + 1'b1) : w_last_sum;
`else
  assign w_a_lat  = bus.a;
  assign w_b_lat  = bus.b;
  assign w_result = w_last_sum;
`endif

  assign bus.in_ready  = rst_n && (r_state == IDLE);
  assign busy          = (r_state != IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.product   = r_product;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_pp_q      <= '0;
      r_product   <= '0;
      r_out_valid <= 1'b0;
`ifdef MUL8_SEQ_SIGNED_EN
      r_sign      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= w_a_lat;
            r_b     <= w_b_lat;
            r_acc   <= '0;
            r_step  <= '0;
            r_state <= MUL;
`ifdef MUL8_SEQ_SIGNED_EN
            r_sign  <= bus.a[OP_W-1] ^ bus.b[OP_W-1];
`endif
          end
        end
        MUL: begin
          r_step <= r_step + 1'b1;
          if (LAT_REG != 0) begin
            // Accumulation lags the multiplier by one step; DRAIN adds the last term.
            r_pp_q <= w_term;
            if (r_step != '0) begin
              r_acc <= r_acc + r_pp_q;
            end
            if (r_step == LAST_STEP) begin
              r_state <= DRAIN;
            end
          end else if (r_step == LAST_STEP) begin
            r_product   <= w_result;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_acc <= r_acc + w_term;
          end
        end
        DRAIN: begin
          r_product   <= w_result;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Testbench for mul8_seq_ctrl: both LAT_REG builds share stimulus; the one
// under test is selected by sel. Directed table, backpressure, mid-op reset
// and randomized traffic against an arithmetic reference model.
module tb_mul8_seq_ctrl;
  import mul8_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        sel;
  logic        busy0;
  logic        busy1;

  logic        w_in_ready;
  logic        w_out_valid;
  logic [15:0] w_product;
  logic        w_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul8_seq_ctrl_if if0 ();
  mul8_seq_ctrl_if if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.a         = a;
  assign if0.b         = b;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.a         = a;
  assign if1.b         = b;
  assign if1.out_ready = out_ready;

  mul8_seq_ctrl #(.LAT_REG(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0), .busy(busy0));
  mul8_seq_ctrl #(.LAT_REG(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1));

  assign w_in_ready  = sel ? if1.in_ready  : if0.in_ready;
  assign w_out_valid = sel ? if1.out_valid : if0.out_valid;
  assign w_product   = sel ? if1.product   : if0.product;
  assign w_busy      = sel ? busy1         : busy0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
`ifdef MUL8_SEQ_SIGNED_EN
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int p  = sx * sy;
    return p[15:0];
`else
    int p = int'(x) * int'(y);
    return p[15:0];
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (sel=%0d): got 0x%0h, expected 0x%0h", nm, sel, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation; leaves the DUT in DONE when out_ready is low.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                       input logic [15:0] exp, input string nm);
    int lat;
    int cnt;
    lat = sel ? 5 : 4;
    cnt = 0;
    while (!w_in_ready && cnt < 20) begin
      tick();
      cnt++;
    end
    check({nm, " in_ready"}, 32'(w_in_ready), 32'd1);
    a = ia;
    b = ib;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({nm, " busy after accept"}, 32'(w_busy), 32'd1);
    cnt = 0;
    while (!w_out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check({nm, " latency"}, 32'(cnt), 32'(lat));
    check({nm, " product"}, 32'(w_product), 32'(exp));
    if (out_ready) begin
      tick();
      check({nm, " out_valid cleared"}, 32'(w_out_valid), 32'd0);
      check({nm, " busy cleared"}, 32'(w_busy), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("reset out_valid", 32'(w_out_valid), 32'd0);
    check("reset product", 32'(w_product), 32'd0);
    check("reset busy", 32'(w_busy), 32'd0);
    check("reset in_ready low", 32'(w_in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post-reset in_ready", 32'(w_in_ready), 32'd1);
  endtask

  task automatic run_random(input int nops);
    logic [15:0] q [$];
    int          accepted;
    int          got;
    int          cyc;
    logic        p_iv, p_ir, p_ov, p_or;
    logic [7:0]  pa, pb;
    logic [15:0] pprod;
    logic [15:0] e;
    accepted = 0;
    got = 0;
    cyc = 0;
    while (got < nops && cyc < 4000) begin
      in_valid  = (accepted < nops) && ($urandom_range(3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom_range(3) != 0);
      p_iv = in_valid;  p_ir = w_in_ready;  pa = a;  pb = b;
      p_ov = w_out_valid;  p_or = out_ready;  pprod = w_product;
      tick();
      cyc++;
      if (p_iv && p_ir) begin
        q.push_back(ref_mul(pa, pb));
        accepted++;
      end
      if (p_ov && p_or) begin
        check("rand result expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("rand product", 32'(pprod), 32'(e));
          got++;
        end
      end
      if (p_ov && !p_or) begin
        check("rand hold", {15'd0, w_out_valid, w_product}, {15'd0, 1'b1, pprod});
      end
    end
    check("rand results count", 32'(got), 32'(nops));
    check("rand queue empty", 32'(q.size()), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
`ifdef MUL8_SEQ_SIGNED_EN
    tbl[0] = '{8'hFF, 8'hFF, 16'h0001};
    tbl[4] = '{8'h80, 8'h7F, 16'hC080};
    tbl[6] = '{8'hFF, 8'h02, 16'hFFFE};
`else
    tbl[0] = '{8'hFF, 8'hFF, 16'hFE01};
    tbl[4] = '{8'h80, 8'h7F, 16'h3F80};
    tbl[6] = '{8'hFF, 8'h02, 16'h01FE};
`endif
    tbl[1] = '{8'h12, 8'h34, 16'h03A8};
    tbl[2] = '{8'h00, 8'hC7, 16'h0000};
    tbl[3] = '{8'h80, 8'h80, 16'h4000};
    tbl[5] = '{8'h0F, 8'h10, 16'h00F0};
    tbl[7] = '{8'h0A, 8'h0B, 16'h006E};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    sel = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();

      for (int i = 0; i < 8; i++) begin
        do_op(tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));
      end

      // Backpressure: result must hold, operands offered during DONE are dropped.
      out_ready = 1'b0;
      do_op(8'h0F, 8'h10, 16'h00F0, "bp");
      for (int i = 0; i < 3; i++) begin
        in_valid = (i == 1);
        a = 8'h01;
        b = 8'h01;
        tick();
        check("bp hold product", 32'(w_product), 32'h00F0);
        check("bp hold out_valid", 32'(w_out_valid), 32'd1);
        check("bp in_ready low", 32'(w_in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("bp in_ready low on out_ready", 32'(w_in_ready), 32'd0);
      tick();
      check("bp released out_valid", 32'(w_out_valid), 32'd0);
      check("bp released busy", 32'(w_busy), 32'd0);
      do_op(8'h01, 8'h01, 16'h0001, "bp next");

      // Reset while the step counter is at 2.
      do_op(8'hFF, 8'hFF, ref_mul(8'hFF, 8'hFF), "pre-rst");
      a = 8'h37;
      b = 8'h59;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      check("midrst out_valid", 32'(w_out_valid), 32'd0);
      check("midrst product", 32'(w_product), 32'd0);
      check("midrst busy", 32'(w_busy), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        tick();
        check("midrst no result", 32'(w_out_valid), 32'd0);
      end
      do_op(8'h0A, 8'h0B, 16'h006E, "post-rst");

      run_random(60);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
